// File: rtl/pipe_pkg.sv
// Shared pipeline definitions: default widths, the zero register and hazard FSM states.
package pipe_pkg;

  localparam int DW_DEF = 32;
  localparam int CW_DEF = 8;
  localparam logic [4:0] REG_ZERO = 5'd0;
  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  typedef enum logic {
    RUN  = 1'b0,
    HOLD = 1'b1
  } hz_state_e;

  // $0 is hard-wired, so a producer targeting it never creates a dependency.
  function automatic logic reg_match(input logic [4:0] prod,
                                     input logic [4:0] rs,
                                     input logic [4:0] rt);
    return (prod != REG_ZERO) && ((prod == rs) || (prod == rt));
  endfunction

endpackage

// File: rtl/hazard_fsm.sv
// Load-use / branch-on-load hazard detection plus the RUN/HOLD bubble sequencer.
module hazard_fsm
  import pipe_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] rs_id,
  input  logic [4:0] rt_id,
  input  logic       branch_id,
  input  logic       mem_read_ex,
  input  logic [4:0] write_reg_ex,
  input  logic       mem_read_em,
  input  logic [4:0] write_reg_em,
  output logic       stall
);

  hz_state_e state, state_nxt;
  logic      hit_ex, hit_em;
  logic      lu, ble, blm;

  assign hit_ex = reg_match(write_reg_ex, rs_id, rt_id);
  assign hit_em = reg_match(write_reg_em, rs_id, rt_id);

  // ALU producers are forwarded; only loads can force a bubble.
  assign lu  = mem_read_ex && !branch_id && hit_ex;
  assign ble = mem_read_ex &&  branch_id && hit_ex;
  assign blm = mem_read_em &&  branch_id && hit_em;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= RUN;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    unique case (state)
      RUN: begin
        if (lu || ble || blm) stall = 1'b1;
        // A branch comparing a load in EX needs the value out of MEM: two bubbles.
        if (ble) state_nxt = HOLD;
      end
      HOLD: begin
        stall     = 1'b1;
        state_nxt = RUN;
      end
      default: state_nxt = RUN;
    endcase
    if (rst) stall = 1'b0;
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard-driven bubble insertion and a saturating bubble counter.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [4:0]    RS_ID,
  input  logic [4:0]    RT_ID,
  input  logic [4:0]    RD_ID,
  input  logic          RegDst_ID,
  input  logic          RegWrite_ID,
  input  logic          MemRead_ID,
  input  logic          Branch_ID,
  input  logic [CW-1:0] Ctrl_ID,
  input  logic [DW-1:0] RD1_ID,
  input  logic [DW-1:0] RD2_ID,
  input  logic [DW-1:0] Imm_ID,
  input  logic [DW-1:0] PC4_ID,
  input  logic          MemRead_EM,
  input  logic [4:0]    WriteReg_EM,
  output logic [4:0]    RS_DE,
  output logic [4:0]    RT_DE,
  output logic [4:0]    WriteReg_EX,
  output logic          RegWrite_EX,
  output logic          MemRead_EX,
  output logic [CW-1:0] Ctrl_EX,
  output logic [DW-1:0] RD1_DE,
  output logic [DW-1:0] RD2_DE,
  output logic [DW-1:0] Imm_DE,
  output logic [DW-1:0] PC4_DE,
  output logic          Stall_IF,
  output logic          Stall_ID,
  output logic [31:0]   StallCnt
);

  logic bubble;

  hazard_fsm u_hazard_fsm (
    .clk          (clk),
    .rst          (rst),
    .rs_id        (RS_ID),
    .rt_id        (RT_ID),
    .branch_id    (Branch_ID),
    .mem_read_ex  (MemRead_EX),
    .write_reg_ex (WriteReg_EX),
    .mem_read_em  (MemRead_EM),
    .write_reg_em (WriteReg_EM),
    .stall        (bubble)
  );

  assign Stall_IF = bubble;
  assign Stall_ID = bubble;

  // A bubble is an all-zero entry, identical to the reset image.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RS_DE       <= REG_ZERO;
      RT_DE       <= REG_ZERO;
      WriteReg_EX <= REG_ZERO;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      Ctrl_EX     <= '0;
      RD1_DE      <= '0;
      RD2_DE      <= '0;
      Imm_DE      <= '0;
      PC4_DE      <= '0;
    end else if (bubble) begin
      RS_DE       <= REG_ZERO;
      RT_DE       <= REG_ZERO;
      WriteReg_EX <= REG_ZERO;
      RegWrite_EX <= 1'b0;
      MemRead_EX  <= 1'b0;
      Ctrl_EX     <= '0;
      RD1_DE      <= '0;
      RD2_DE      <= '0;
      Imm_DE      <= '0;
      PC4_DE      <= '0;
    end else begin
      RS_DE       <= RS_ID;
      RT_DE       <= RT_ID;
      WriteReg_EX <= RegDst_ID ? RD_ID : RT_ID;
      RegWrite_EX <= RegWrite_ID;
      MemRead_EX  <= MemRead_ID;
      Ctrl_EX     <= Ctrl_ID;
      RD1_DE      <= RD1_ID;
      RD2_DE      <= RD2_ID;
      Imm_DE      <= Imm_ID;
      PC4_DE      <= PC4_ID;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                               StallCnt <= 32'd0;
    else if (bubble && StallCnt != CNT_MAX) StallCnt <= StallCnt + 32'd1;
  end

endmodule

// File: doc/id_ex_stage.md
ID_EX_STAGE -- requirements
Module: id_ex_stage

Interface
REQ-001 SHALL have parameter DW, default 32, datapath word width.
REQ-002 SHALL have parameter CW, default 8, width of opaque EX/MEM/WB control bundle.
REQ-003 SHALL have ports clk in 1 (sole clock, rising edge), and rst in 1 (asynchronous, active-high).
REQ-004 SHALL have inputs RS_ID, RT_ID, RD_ID, each 5 bits: ID-stage register specifiers.
REQ-005 SHALL have inputs RegDst_ID, RegWrite_ID, MemRead_ID, Branch_ID, each 1 bit: ID decode flags.
REQ-006 SHALL have input Ctrl_ID, CW bits: remaining decoded control.
REQ-007 SHALL have inputs RD1_ID, RD2_ID, Imm_ID, PC4_ID, each DW bits: ID operands.
REQ-008 SHALL have inputs MemRead_EM 1 and WriteReg_EM 5: load-in-MEM status from EX/MEM register.
REQ-009 SHALL have outputs RS_DE, RT_DE, WriteReg_EX (5 each), RegWrite_EX, MemRead_EX (1 each), Ctrl_EX (CW), RD1_DE, RD2_DE, Imm_DE, PC4_DE (DW each): registered ID/EX contents.
REQ-010 SHALL have outputs Stall_IF, Stall_ID (1 each): hold PC and IF/ID register.
REQ-011 SHALL have output StallCnt, 32 bits: bubble-cycle counter.

Function
REQ-012 SHALL, in a non-stall cycle, capture all ID inputs into the *_DE/*_EX registers on the rising clk edge, giving one-cycle latency.
REQ-013 SHALL compute WriteReg_EX as the registered value of RegDst_ID ? RD_ID : RT_ID.
REQ-014 SHALL define a match as: the producer register is nonzero and equals RS_ID or RT_ID.
REQ-015 SHALL detect a load-use hazard (LU) when MemRead_EX is set, Branch_ID is clear, and WriteReg_EX matches.
REQ-016 SHALL detect a branch-on-load-in-EX hazard (BLE) when Branch_ID and MemRead_EX are set and WriteReg_EX matches.
REQ-017 SHALL detect a branch-on-load-in-MEM hazard (BLM) when Branch_ID and MemRead_EM are set and WriteReg_EM matches.
REQ-018 SHALL NOT stall a branch on an ALU result in EX or MEM; forwarding covers those cases.
REQ-019 SHALL implement FSM states RUN and HOLD.
REQ-020 SHALL, in RUN with LU, BLE or BLM detected, assert Stall_IF and Stall_ID combinationally that cycle and load a bubble.
REQ-021 SHALL transition RUN->HOLD on BLE only; RUN->RUN otherwise.
REQ-022 SHALL, in HOLD, unconditionally assert both stalls, load a bubble, and return to RUN; BLE therefore yields exactly 2 bubbles, LU and BLM 1 each.
REQ-023 SHALL define a bubble as RegWrite_EX=0, MemRead_EX=0, Ctrl_EX=0, WriteReg_EX=0, RS_DE=0, RT_DE=0; data registers are don't-care but SHALL be zeroed.
REQ-024 SHALL give HOLD priority over new detection; detection SHALL NOT be re-evaluated in HOLD.
REQ-025 SHALL increment StallCnt by 1 per bubble cycle and saturate at 0xFFFFFFFF (no wrap).
REQ-026 SHALL give register 0 no hazard, even when WriteReg matches.

Reset
REQ-027 SHALL, while rst=1, asynchronously force state=RUN, StallCnt=0 and all ID/EX registers to bubble values (all zero).
REQ-028 SHALL hold Stall_IF=Stall_ID=0 during reset; rst asserted mid-HOLD SHALL abort the second bubble.

Structure
REQ-029 SHALL take the FSM state enum, DW/CW defaults and REG_ZERO (5'd0) from shared package pipe_pkg.
REQ-030 SHALL place hazard detection plus FSM in sub-module hazard_fsm, instantiated once; the pipeline register and counter SHALL stay in id_ex_stage.

Verification
REQ-031 SHALL cover: lw $2 in EX (MemRead_EX=1, WriteReg_EX=2), add RS_ID=2 in ID -> Stall_IF=Stall_ID=1 for 1 cycle, next EX bubble (RegWrite_EX=0), StallCnt=1.
REQ-032 SHALL cover: lw $5 in EX, beq RS_ID=5, Branch_ID=1 -> stalls for exactly 2 consecutive cycles, FSM RUN->HOLD->RUN, StallCnt +2.
REQ-033 SHALL cover: MemRead_EM=1, WriteReg_EM=7, beq RT_ID=7 -> 1 stall cycle; the same case with WriteReg_EM=0 and RT_ID=0 -> no stall.
REQ-034 SHALL cover: ALU producer RegWrite_EX=1, MemRead_EX=0, WriteReg_EX=3, beq RS_ID=3 -> no stall, ID fields appear on *_DE next cycle.
REQ-035 SHALL cover: rst pulse asserted in HOLD between clock edges -> outputs zero immediately, state RUN, Stall_IF=0 after release.
REQ-036 SHALL cover: StallCnt preset near saturation (0xFFFFFFFE) with 3 bubbles -> StallCnt holds at 0xFFFFFFFF.
